// File: rtl/async_fifo_wr_ctrl_if.sv
// Write-side bundle of the async FIFO controller: producer request, RAM
// write strobe/address, pointer exchange with the read domain and flags.
// Optional FIFO_OVF_DETECT_EN adds the sticky overflow error and its clear.
interface async_fifo_wr_ctrl_if #(
  parameter int unsigned ADDR_W = 4
);
  logic              wr_req;
  logic [ADDR_W:0]   rd_ptr_gray;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W:0]   wr_ptr_gray;
  logic              full;
  logic              almost_full;
  logic [ADDR_W:0]   fill_level;
`ifdef FIFO_OVF_DETECT_EN
  logic              ovf_clr;
  logic              ovf_err;
`endif

  // Producer / read-domain side.
  modport master (
    output wr_req, rd_ptr_gray,
`ifdef FIFO_OVF_DETECT_EN
    output ovf_clr,
    input  ovf_err,
`endif
    input  wr_en, wr_addr, wr_ptr_gray, full, almost_full, fill_level
  );

  // Write controller side.
  modport slave (
    input  wr_req, rd_ptr_gray,
`ifdef FIFO_OVF_DETECT_EN
    input  ovf_clr,
    output ovf_err,
`endif
    output wr_en, wr_addr, wr_ptr_gray, full, almost_full, fill_level
  );
endinterface

// File: rtl/async_fifo_wr_ctrl.sv
// Write-domain pointer/flag controller for an async FIFO.
// Owns binary/gray write pointers, synchronises the gray read pointer through
// SYNC_STAGES flops, and produces registered full, almost_full and fill_level.
// Optional feature macro: FIFO_OVF_DETECT_EN (sticky ovf_err on dropped writes).
module async_fifo_wr_ctrl #(
  parameter int unsigned ADDR_W      = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned AF_THRESH   = (1 << ADDR_W) - 2
) (
  input  logic                  clk,
  input  logic                  reset,
  async_fifo_wr_ctrl_if.slave   bus
);

  localparam int unsigned     PW      = ADDR_W + 1;
  localparam logic [ADDR_W:0] DEPTH_V = PW'(1 << ADDR_W);
  localparam logic [ADDR_W:0] AF_V    = PW'(AF_THRESH);

  logic [ADDR_W:0] wptr_bin;
  logic [ADDR_W:0] wptr_next;
  logic [ADDR_W:0] wr_ptr_gray_q;
  logic [ADDR_W:0] rptr_bin;
  logic [ADDR_W:0] fill_next;
  logic [ADDR_W:0] fill_q;
  logic [ADDR_W:0] sync_q [SYNC_STAGES];
  logic            full_q;
  logic            af_q;
  logic            wr_en_int;

  // Requests are ignored while reset is held, and dropped while full.
  assign wr_en_int = bus.wr_req & ~full_q & ~reset;

  assign wptr_next = wptr_bin + PW'(wr_en_int);
  assign fill_next = wptr_next - rptr_bin;

  assign bus.wr_en       = wr_en_int;
  assign bus.wr_addr     = wptr_bin[ADDR_W-1:0];
  assign bus.wr_ptr_gray = wr_ptr_gray_q;
  assign bus.full        = full_q;
  assign bus.almost_full = af_q;
  assign bus.fill_level  = fill_q;

  // Read-pointer synchroniser chain into the write clock domain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= bus.rd_ptr_gray;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  // Gray to binary: each binary bit is the XOR of all gray bits at or above it.
  always_comb begin
    rptr_bin = '0;
    for (int unsigned i = 0; i < PW; i++) begin
      rptr_bin[i] = ^(sync_q[SYNC_STAGES-1] >> i);
    end
  end

  // Write pointers and flags, all computed from the post-write pointer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_bin      <= '0;
      wr_ptr_gray_q <= '0;
      fill_q        <= '0;
      full_q        <= 1'b0;
      af_q          <= 1'b0;
    end else begin
      wptr_bin      <= wptr_next;
      wr_ptr_gray_q <= wptr_next ^ (wptr_next >> 1);
      fill_q        <= fill_next;
      // Values above DEPTH mean a broken read side; still report full.
      full_q        <= (fill_next >= DEPTH_V);
      af_q          <= (fill_next >= AF_V);
    end
  end

`ifdef FIFO_OVF_DETECT_EN
  logic ovf_q;
  assign bus.ovf_err = ovf_q;

  // Sticky overflow error; a new overflow wins over a simultaneous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_q <= 1'b0;
    end else if (bus.wr_req & full_q) begin
      ovf_q <= 1'b1;
    end else if (bus.ovf_clr) begin
      ovf_q <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_async_fifo_wr_ctrl.sv
// Directed bench for async_fifo_wr_ctrl (ADDR_W=4, SYNC_STAGES=2, AF_THRESH=14).
module tb_async_fifo_wr_ctrl;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  async_fifo_wr_ctrl_if #(.ADDR_W(4)) bus ();

  async_fifo_wr_ctrl #(
    .ADDR_W      (4),
    .SYNC_STAGES (2),
    .AF_THRESH   (14)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] gray(input int unsigned v);
    logic [4:0] b;
    b = 5'(v % 32);
    return b ^ (b >> 1);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    failures++;
    $error("FAIL timeout: stimulus did not complete");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    logic [4:0] exp_fill;
    logic [4:0] prev_g;
    int unsigned rd_at;

    reset           = 1'b1;
    bus.wr_req      = 1'b0;
    bus.rd_ptr_gray = '0;
`ifdef FIFO_OVF_DETECT_EN
    bus.ovf_clr     = 1'b0;
`endif

    #3;
    bus.wr_req = 1'b1;
    #1;
    check("rst_wr_en", bus.wr_en, 1'b0);
    check("rst_addr", bus.wr_addr, 4'd0);
    check("rst_gray", bus.wr_ptr_gray, 5'd0);
    check("rst_fill", bus.fill_level, 5'd0);
    check("rst_full", bus.full, 1'b0);
    check("rst_af", bus.almost_full, 1'b0);
`ifdef FIFO_OVF_DETECT_EN
    check("rst_ovf", bus.ovf_err, 1'b0);
`endif
    bus.wr_req = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    for (int unsigned k = 1; k <= 16; k++) begin
      bus.wr_req = 1'b1;
      #1;
      check("t1_wr_en", bus.wr_en, 1'b1);
      check("t1_addr", bus.wr_addr, 4'(k - 1));
      tick();
      check("t1_fill", bus.fill_level, 5'(k));
      check("t1_af", bus.almost_full, (k >= 14));
      check("t1_full", bus.full, (k == 16));
      check("t1_gray", bus.wr_ptr_gray, gray(k));
    end
    #1;
    check("t1_drop_wr_en", bus.wr_en, 1'b0);
    check("t1_drop_addr", bus.wr_addr, 4'd0);
    tick();
    check("t1_drop_fill", bus.fill_level, 5'd16);
    check("t1_drop_gray", bus.wr_ptr_gray, 5'b11000);
    check("t1_drop_full", bus.full, 1'b1);

    bus.wr_req      = 1'b0;
    bus.rd_ptr_gray = 5'b00110;
    tick();
    check("t2_full_e1", bus.full, 1'b1);
    tick();
    check("t2_full_e2", bus.full, 1'b1);
    check("t2_fill_e2", bus.fill_level, 5'd16);
    tick();
    check("t2_full_e3", bus.full, 1'b0);
    check("t2_fill_e3", bus.fill_level, 5'd12);
    check("t2_af_e3", bus.almost_full, 1'b0);

    prev_g = gray(16);
    for (int unsigned n = 1; n <= 104; n++) begin
      bus.wr_req      = 1'b1;
      bus.rd_ptr_gray = gray(4 + n);
      tick();
      rd_at    = (n >= 3) ? (4 + n - 2) : 4;
      exp_fill = 5'((16 + n - rd_at) % 32);
      check("t3_fill", bus.fill_level, exp_fill);
      check("t3_gray", bus.wr_ptr_gray, gray(16 + n));
      check("t4_hamming", $countones(bus.wr_ptr_gray ^ prev_g), 1);
      check("t3_full", bus.full, 1'b0);
      if (n == 16) begin
        check("t3_wrap_prev", prev_g, 5'b10000);
        check("t3_wrap_zero", bus.wr_ptr_gray, 5'b00000);
      end
      prev_g = bus.wr_ptr_gray;
    end

    bus.wr_req = 1'b0;
    tick();
    tick();
    tick();
    check("t5_fill12", bus.fill_level, 5'd12);
    bus.rd_ptr_gray = gray(111);
    tick();
    tick();
    tick();
    check("t5_fill9", bus.fill_level, 5'd9);
    check("t5_addr_pre", bus.wr_addr, 4'd8);

    #3;
    reset           = 1'b1;
    bus.rd_ptr_gray = '0;
    bus.wr_req      = 1'b1;
    #1;
    check("t5_fill", bus.fill_level, 5'd0);
    check("t5_gray", bus.wr_ptr_gray, 5'd0);
    check("t5_addr", bus.wr_addr, 4'd0);
    check("t5_full", bus.full, 1'b0);
    check("t5_af", bus.almost_full, 1'b0);
    check("t5_wr_en", bus.wr_en, 1'b0);
    tick();
    check("t5_hold_fill", bus.fill_level, 5'd0);
    bus.wr_req = 1'b0;
    reset      = 1'b0;
    tick();

`ifdef FIFO_OVF_DETECT_EN
    for (int unsigned k = 1; k <= 16; k++) begin
      bus.wr_req = 1'b1;
      tick();
    end
    check("t6_full", bus.full, 1'b1);
    check("t6_ovf_before", bus.ovf_err, 1'b0);
    tick();
    check("t6_ovf_set", bus.ovf_err, 1'b1);
    bus.wr_req = 1'b0;
    tick();
    tick();
    check("t6_ovf_hold", bus.ovf_err, 1'b1);
    bus.ovf_clr = 1'b1;
    tick();
    check("t6_ovf_clr", bus.ovf_err, 1'b0);
    bus.wr_req = 1'b1;
    tick();
    check("t6_ovf_set_wins", bus.ovf_err, 1'b1);
    bus.wr_req  = 1'b0;
    bus.ovf_clr = 1'b0;
    tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
